// File: rtl/mem_pkg.sv
// Shared encodings for the sized byte memory: access sizes, FSM states and a size helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic logic [3:0] size_bytes(logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/mem_extend.sv
// Takes the eight bytes starting at the access address (first byte in the MSB) and returns the
// accessed item right-aligned, sign- or zero-extended to 64 bits.
module mem_extend
    import mem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  size_e       size_i,
    input  logic        zext_i,
    output logic [63:0] data_o
);

    logic sign;

    always_comb begin
        data_o = '0;
        sign   = 1'b0;
        unique case (size_i)
            SZ_B: begin
                sign   = ~zext_i & raw_i[63];
                data_o = {{56{sign}}, raw_i[63:56]};
            end
            SZ_H: begin
                sign   = ~zext_i & raw_i[63];
                data_o = {{48{sign}}, raw_i[63:48]};
            end
            SZ_W: begin
                sign   = ~zext_i & raw_i[63];
                data_o = {{32{sign}}, raw_i[63:32]};
            end
            SZ_D: data_o = raw_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/sized_memory.sv
// Big-endian byte-addressed memory with byte/half/word/double accesses and a fixed response
// latency; stores commit and loads sample the array on the acceptance edge.
module sized_memory
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        init_q;
    logic [63:0] pend_rdata_q, pend_rdata_d;
    logic        pend_err_q, pend_err_d;
    logic [63:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [7:0]  mem_q [DEPTH];

    logic        accept;
    logic [3:0]  nbytes;
    logic        misaligned;
    logic        out_of_range;
    logic        acc_err;
    logic [63:0] raw;
    logic [63:0] load_data;
    logic [63:0] wdata_left;

    assign accept       = req_valid && req_ready;
    assign nbytes       = size_bytes(req_size);
    assign misaligned   = (req_addr & 64'(nbytes - 4'd1)) != 64'd0;
    // 65-bit sum so addresses near 2^64 cannot wrap back into range
    assign out_of_range = ({1'b0, req_addr} + 65'(nbytes)) > 65'(DEPTH);
    assign acc_err      = misaligned || out_of_range;
    assign wdata_left   = req_wdata << (7'd64 - {nbytes, 3'b000});

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[63-8*i -: 8] = mem_q[req_addr[AW-1:0] + AW'(i)];
        end
    end

    mem_extend u_extend (
        .raw_i  (raw),
        .size_i (size_e'(req_size)),
        .zext_i (req_unsigned),
        .data_o (load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d      = (LATENCY == 1) ? StResp : StBusy;
                    cnt_d        = CntInit;
                    pend_err_d   = acc_err;
                    pend_rdata_d = (acc_err || req_write) ? 64'd0 : load_data;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            init_q       <= 1'b0;
            pend_rdata_q <= 64'd0;
            pend_err_q   <= 1'b0;
            rsp_rdata_q  <= 64'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_q       <= 1'b1;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            // Response fields only change on entry to RESP so they hold between responses
            if (state_d == StResp) begin
                rsp_rdata_q <= pend_rdata_d;
                rsp_err_q   <= pend_err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(nbytes)) begin
                    mem_q[req_addr[AW-1:0] + AW'(i)] <= wdata_left[63-8*i -: 8];
                end
            end
        end
    end

    assign req_ready = init_q && (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_err_q;

endmodule

// File: tb/tb_sized_memory.sv
// Drives a LATENCY=1 and a LATENCY=3 instance with identical requests and checks both against a
// byte-array reference model plus directed vectors.
module tb_sized_memory;

    localparam int unsigned Depth = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        r1_ready, r1_valid, r1_err;
    logic        r3_ready, r3_valid, r3_err;
    logic [63:0] r1_rdata, r3_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [Depth];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        err;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sized_memory #(.DEPTH(Depth), .LATENCY(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (r1_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (r1_valid),
        .rsp_rdata    (r1_rdata),
        .rsp_error    (r1_err)
    );

    sized_memory #(.DEPTH(Depth), .LATENCY(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (r3_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (r3_valid),
        .rsp_rdata    (r3_rdata),
        .rsp_error    (r3_err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic model_err(logic [63:0] a, logic [1:0] sz);
        longint unsigned n = longint'(1) << sz;
        return ((a % n) != 0) || (a > (Depth - n));
    endfunction

    function automatic logic [63:0] model_load(logic [63:0] a, logic [1:0] sz, logic u);
        int          n    = 1 << sz;
        int          bits = 8 * n;
        logic [63:0] v    = 64'd0;
        if (model_err(a, sz)) return 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[int'(a) + i]);
        if (!u && bits < 64 && v[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
        int n = 1 << sz;
        if (!model_err(a, sz)) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && !(r1_ready && r3_ready); k++) @(negedge clk);
        chk("ready_wait", 64'(r1_ready && r3_ready), 64'd1);
    endtask

    // Issue one request to both instances and check latency, data, error and hold.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_err, input string name);
        int          lat1 = 0;
        int          lat3 = 0;
        logic [63:0] d1 = 64'd0, d3 = 64'd0;
        logic        e1 = 1'b0, e3 = 1'b0;
        wait_ready();
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b1;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        if (w) model_store(a, sz, wd);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (r1_valid && lat1 == 0) begin lat1 = n; d1 = r1_rdata; e1 = r1_err; end
            if (r3_valid && lat3 == 0) begin lat3 = n; d3 = r3_rdata; e3 = r3_err; end
            if (lat1 != 0 && lat3 != 0) break;
        end
        chk({name, "_lat1"}, 64'(lat1), 64'd1);
        chk({name, "_lat3"}, 64'(lat3), 64'd3);
        chk({name, "_rd1"}, d1, exp_rd);
        chk({name, "_rd3"}, d3, exp_rd);
        chk({name, "_err1"}, 64'(e1), 64'(exp_err));
        chk({name, "_err3"}, 64'(e3), 64'(exp_err));
        @(negedge clk);
        chk({name, "_hold3"}, r3_rdata, exp_rd);
    endtask

    task automatic rnd_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [63:0] a, input logic [63:0] wd, input string name);
        logic [63:0] e_rd  = w ? 64'd0 : model_load(a, sz, u);
        logic        e_err = model_err(a, sz);
        do_req(w, sz, u, a, wd, e_rd, e_err, name);
    endtask

    initial begin
        int acc[$];
        int rsp[$];
        bit saw;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready1", 64'(r1_ready), 64'd0);
        chk("rst_ready3", 64'(r3_ready), 64'd0);
        chk("rst_valid", 64'(r1_valid | r3_valid), 64'd0);
        chk("rst_rdata", r1_rdata | r3_rdata, 64'd0);
        chk("rst_err", 64'(r1_err | r3_err), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 64'(r1_ready | r3_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", 64'(r1_ready & r3_ready), 64'd1);
        @(negedge clk);

        tbl.push_back('{1, 3, 0, 64'd16, 64'h0102030405060708, 64'd0, 0, "st_d16"});
        tbl.push_back('{0, 3, 0, 64'd16, 64'd0, 64'h0102030405060708, 0, "ld_d16"});
        tbl.push_back('{0, 0, 1, 64'd16, 64'd0, 64'h01, 0, "ld_b16"});
        tbl.push_back('{0, 0, 1, 64'd23, 64'd0, 64'h08, 0, "ld_b23"});
        tbl.push_back('{1, 0, 0, 64'd3, 64'h123456789ABCDE80, 64'd0, 0, "st_b3"});
        tbl.push_back('{0, 0, 0, 64'd3, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, "ld_b3_s"});
        tbl.push_back('{0, 0, 1, 64'd3, 64'd0, 64'h0000000000000080, 0, "ld_b3_u"});
        tbl.push_back('{0, 2, 0, 64'd6, 64'd0, 64'd0, 1, "ld_w6_mis"});
        tbl.push_back('{1, 2, 0, 64'd4, 64'h11223344, 64'd0, 0, "st_w4"});
        tbl.push_back('{1, 1, 0, 64'd5, 64'hBEEF, 64'd0, 1, "st_h5_mis"});
        tbl.push_back('{0, 2, 1, 64'd4, 64'd0, 64'h11223344, 0, "ld_w4_kept"});
        tbl.push_back('{1, 1, 0, 64'd8, 64'h8001, 64'd0, 0, "st_h8"});
        tbl.push_back('{0, 1, 0, 64'd8, 64'd0, 64'hFFFFFFFFFFFF8001, 0, "ld_h8_s"});
        tbl.push_back('{0, 1, 1, 64'd8, 64'd0, 64'h8001, 0, "ld_h8_u"});
        tbl.push_back('{1, 2, 0, 64'd12, 64'hF0000000, 64'd0, 0, "st_w12"});
        tbl.push_back('{0, 2, 0, 64'd12, 64'd0, 64'hFFFFFFFFF0000000, 0, "ld_w12_s"});
        tbl.push_back('{1, 3, 0, 64'd2040, 64'hCAFEF00D12345678, 64'd0, 0, "st_d2040"});
        tbl.push_back('{0, 3, 0, 64'd2044, 64'd0, 64'd0, 1, "ld_d2044_oor"});
        tbl.push_back('{0, 3, 0, 64'd2040, 64'd0, 64'hCAFEF00D12345678, 0, "ld_d2040"});
        tbl.push_back('{0, 0, 0, 64'd2047, 64'd0, 64'h78, 0, "ld_b2047"});
        tbl.push_back('{0, 3, 0, 64'd2048, 64'd0, 64'd0, 1, "ld_d2048_oor"});
        tbl.push_back('{0, 3, 1, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1, "ld_d_wrap"});
        tbl.push_back('{1, 3, 0, 64'd2044, 64'h1111111111111111, 64'd0, 1, "st_d2044"});
        tbl.push_back('{0, 3, 1, 64'd2040, 64'd0, 64'hCAFEF00D12345678, 0, "ld_d2040_b"});

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wd, tbl[i].rd,
                   tbl[i].err, tbl[i].name);
        end

        // Back-to-back loads with req_valid held: LATENCY=3 instance accepts every 4 cycles.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'd16;
        for (int k = 0; k < 24; k++) begin
            if (r3_ready) acc.push_back(k);
            if (r3_valid) rsp.push_back(k);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_n_acc", 64'(acc.size()), 64'd6);
        chk("b2b_n_rsp", 64'(rsp.size()), 64'd6);
        for (int i = 0; i < acc.size() && i < rsp.size(); i++) begin
            chk("b2b_acc_time", 64'(acc[i]), 64'(4 * i));
            chk("b2b_rsp_time", 64'(rsp[i]), 64'(acc[i] + 3));
        end

        for (int a = 0; a < 256; a += 8) begin
            rnd_req(1'b1, 2'd3, 1'b0, 64'(a), {$urandom, $urandom}, "init");
        end
        for (int i = 0; i < 80; i++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 4) == 0) ? 64'($urandom_range(2040, 2055))
                                            : 64'($urandom_range(0, 255));
            rnd_req(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom}, "rnd");
        end

        // Reset one cycle after a store is accepted: response dropped, store kept.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_mem[0] = 8'hAA;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r3_valid) saw = 1'b1;
        end
        chk("midrst_no_rsp", 64'(saw), 64'd0);
        chk("midrst_ready", 64'(r1_ready | r3_ready), 64'd0);
        chk("midrst_rdata", r3_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_up", 64'(r1_ready & r3_ready), 64'd1);
        @(negedge clk);
        do_req(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFAA, 1'b0, "ld_b0_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sized_memory.md
SIZED_MEMORY -- requirements
Module: sized_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning byte-array size (power of two, >= 8).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to response (legal 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  64  byte address.
REQ-011 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  64  load result, right-aligned and extended.
REQ-014 SHALL have port rsp_error  output  1  access was misaligned or out of range; qualified by rsp_valid.

Function
REQ-015 SHALL store bytes big-endian: the byte at req_addr is the most significant byte of the accessed item.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; this edge is the acceptance edge.
REQ-017 SHALL implement FSM IDLE -> BUSY on acceptance; BUSY counts down LATENCY-1 cycles -> RESP; RESP -> IDLE after one cycle.
REQ-018 SHALL drive req_ready = 1 only in IDLE, so the next acceptance occurs no earlier than LATENCY+1 cycles after the previous one.
REQ-019 SHALL drive rsp_valid = 1 only in RESP, exactly LATENCY cycles after the acceptance edge. For LATENCY = 1, BUSY is skipped and the FSM goes IDLE -> RESP.
REQ-020 SHALL commit store bytes and capture load bytes at the acceptance edge, so a load issued after a store always returns the stored data.
REQ-021 SHALL, for a store of N = 2^req_size bytes, write req_wdata[8N-1:0] to addresses req_addr .. req_addr+N-1, with the MSB at req_addr; other bytes SHALL be unchanged.
REQ-022 SHALL return loads in rsp_rdata[8N-1:0], sign-extended or zero-extended to 64 bits according to req_unsigned; for size 3, req_unsigned has no effect.
REQ-023 SHALL flag misalignment when req_addr mod N != 0.
REQ-024 SHALL flag out-of-range when req_addr + N > DEPTH, evaluated on the full 64-bit address without wrap-around.
REQ-025 SHALL, on misalignment or out-of-range, suppress any write, return rsp_rdata = 0 and rsp_error = 1.
REQ-026 SHALL hold rsp_rdata and rsp_error stable from RESP until the next RESP; store responses SHALL return rsp_rdata = 0.
REQ-027 SHALL ignore req_* inputs while req_ready = 0.

Reset
REQ-028 SHALL, while rst_n = 0, force the FSM to IDLE, the counter to 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0 and req_ready = 0.
REQ-029 SHALL raise req_ready on the first rising edge after rst_n deasserts.
REQ-030 SHALL, on reset mid-operation, drop the pending response; an already-committed store SHALL remain in the array.
REQ-031 SHALL not reset the byte array; the array is not initialised.

Structure
REQ-032 SHALL place the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state encodings in shared package mem_pkg.
REQ-033 SHALL use one sub-module, mem_extend (combinational byte gather plus sign/zero extension), instantiated once.

Verification
REQ-034 Bench SHALL cover: store double 0x0102030405060708 at address 16, then load double at 16 -> rsp_rdata = 0x0102030405060708, with byte[16] = 0x01 and byte[23] = 0x08.
REQ-035 Bench SHALL cover: store byte 0x80 at address 3, then load signed byte at 3 -> 0xFFFFFFFFFFFFFF80; unsigned load -> 0x0000000000000080.
REQ-036 Bench SHALL cover: load word at address 6 -> rsp_error = 1, rsp_rdata = 0; store half at address 5 -> rsp_error = 1 and memory unchanged.
REQ-037 Bench SHALL cover: with DEPTH = 2048, load double at address 2044 -> rsp_error = 1; load double at address 2040 -> rsp_error = 0.
REQ-038 Bench SHALL cover: with LATENCY = 3 and req_valid held high continuously -> rsp_valid pulses 3 cycles after each acceptance, with acceptances 4 cycles apart.
REQ-039 Bench SHALL cover: assert rst_n = 0 one cycle after accepting a store of 0xAA to address 0 (LATENCY = 3) -> no rsp_valid; after reset, load byte at 0 returns 0xFFFFFFFFFFFFFFAA (signed).
